// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_pkg
//  Description : Shared FSM encoding and default synchronizer depth for the
//                CDC bus transmitter.
//  Revision    : 1.0
// ============================================================================
package cdc_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } cdc_state_t;

    localparam int c_sync_depth_default = 2;

endpackage : cdc_pkg
`default_nettype wire

// File: rtl/signal_sync.sv
`default_nettype none
// ============================================================================
//  Module      : signal_sync
//  Description : Multi-flop synchronizer for signals entering the clk domain.
//  Revision    : 1.0
// ============================================================================
module signal_sync #(
    parameter int Width = 1,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] r_stages [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_stages[i] <= '0;
            end
        end else begin
            r_stages[0] <= d;
            for (int i = 1; i < Depth; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign q = r_stages[Depth-1];

endmodule : signal_sync
`default_nettype wire

// File: rtl/cdc_bus_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_bus_tx
//  Description : Source side of a two-phase toggle bus handshake; holds the
//                word stable until the synchronized ack toggle matches.
//                Optional WAIT_ACK timeout: define CDC_BUS_TX_TIMEOUT_EN.
//  Revision    : 1.0
// ============================================================================
module cdc_bus_tx
    import cdc_pkg::*;
#(
    parameter int Width         = 32,
    parameter int SyncDepth     = c_sync_depth_default,
    parameter int TimeoutCycles = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic [Width-1:0] xfer_data,
    output logic             xfer_req,
    input  logic             xfer_ack,
    output logic             done,
    output logic             timeout_err
);

    cdc_state_t       r_state;
    logic             r_req;
    logic [Width-1:0] r_data;
    logic             r_done;
    logic             w_ack_s;
    logic             w_accept;

    signal_sync #(
        .Width (1),
        .Depth (SyncDepth)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (xfer_ack),
        .q     (w_ack_s)
    );

    assign w_accept = (r_state == IDLE) && in_valid;

    // ack_s is only looked at in WAIT_ACK; a stray ack toggle in IDLE is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_req   <= ~r_req;
                        r_state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (w_ack_s == r_req) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign xfer_data = r_data;
    assign xfer_req  = r_req;
    assign done      = r_done;

`ifdef CDC_BUS_TX_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TimeoutCycles + 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_timeout;

    // Counter saturates at TimeoutCycles; the flag is sticky and the FSM keeps waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == WAIT_ACK) && (r_cnt != c_cnt_w'(TimeoutCycles))) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (r_cnt == c_cnt_w'(TimeoutCycles - 1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout;
`else
    assign timeout_err = 1'b0;
`endif

endmodule : cdc_bus_tx
`default_nettype wire

// File: tb/tb_cdc_bus_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_bus_tx
//  Description : Directed self-checking bench for cdc_bus_tx (SyncDepth = 2,
//                TimeoutCycles = 8); timeout expectations follow
//                CDC_BUS_TX_TIMEOUT_EN.
//  Revision    : 1.0
// ============================================================================
module tb_cdc_bus_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] xfer_data;
    logic        xfer_req;
    logic        done;
    logic        timeout_err;
    logic        ack_manual = 1'b0;
    logic        ack_echo;
    logic        echo_en = 1'b0;
    wire         xfer_ack = echo_en ? ack_echo : ack_manual;

    int checks = 0;
    int errors = 0;

    int          n_done = 0;
    int          n_tog = 0;
    int          n_unstable = 0;
    logic [31:0] recv [$];
    logic        prev_req = 1'b0;
    logic        prev_ready = 1'b1;
    logic [31:0] prev_data = '0;

    cdc_bus_tx #(
        .Width         (32),
        .SyncDepth     (2),
        .TimeoutCycles (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .xfer_data   (xfer_data),
        .xfer_req    (xfer_req),
        .xfer_ack    (xfer_ack),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Destination model: echoes the request toggle back one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_echo <= 1'b0;
        else        ack_echo <= xfer_req;
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done <= n_done + 1;
            recv.push_back(xfer_data);
        end
        if (xfer_req !== prev_req) n_tog <= n_tog + 1;
        if (!in_ready && !prev_ready && (xfer_data !== prev_data)) n_unstable <= n_unstable + 1;
        prev_req   <= xfer_req;
        prev_ready <= in_ready;
        prev_data  <= xfer_data;
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        ack_manual = 1'b0;
        echo_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, xfer_req, done, timeout_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/req/done/to=%b exp 1000", {in_ready, xfer_req, done, timeout_err});
        end
        checks++;
        if (xfer_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 00000000", xfer_data);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b done=%b exp rdy=1 done=0", in_ready, done);
        end
    endtask

    task automatic test_accept();
        logic [3:0] dseq;
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = 32'h0;
        @(negedge clk);
        checks++;
        if (xfer_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL accept_data got %h exp deadbeef", xfer_data);
        end
        checks++;
        if (xfer_req !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_ctrl got req=%b rdy=%b exp req=1 rdy=0", xfer_req, in_ready);
        end
        ack_manual = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            dseq[i] = done;
        end
        checks++;
        if (dseq !== 4'b0010) begin
            errors++;
            $display("FAIL accept_done_latency got %b exp 0010", dseq);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready_after_done got %b exp 1", in_ready);
        end
    endtask

    task automatic test_idle_ack();
        int nd = 0;
        int nlow = 0;
        ack_manual = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0) nd++;
            if (in_ready !== 1'b1) nlow++;
        end
        checks++;
        if (nd != 0 || nlow != 0) begin
            errors++;
            $display("FAIL idle_ack got done_cycles=%0d busy_cycles=%0d exp 0 0", nd, nlow);
        end
        checks++;
        if (xfer_req !== 1'b1) begin
            errors++;
            $display("FAIL idle_ack_req got %b exp 1", xfer_req);
        end
    endtask

    task automatic test_reset_mid_wait();
        int nd = 0;
        do_reset();
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = 32'hCAFEF00D;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || xfer_req !== 1'b1) begin
            errors++;
            $display("FAIL midwait_pre got rdy=%b req=%b exp rdy=0 req=1", in_ready, xfer_req);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, xfer_req, done} !== 3'b100 || xfer_data !== 32'h0) begin
            errors++;
            $display("FAIL midwait_async got rdy/req/done=%b data=%h exp 100 00000000",
                     {in_ready, xfer_req, done}, xfer_data);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0) nd++;
        end
        checks++;
        if (nd != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midwait_after got done_cycles=%0d rdy=%b exp 0 1", nd, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [4];
        int   d0, t0, u0, r0, idx, budget;
        logic acc;
        w[0] = 32'h11223344;
        w[1] = 32'h55667788;
        w[2] = 32'h99AABBCC;
        w[3] = 32'hDDEEFF00;
        do_reset();
        echo_en = 1'b1;
        d0 = n_done;
        t0 = n_tog;
        u0 = n_unstable;
        r0 = recv.size();
        idx = 0;
        budget = 0;
        in_valid = 1'b1;
        in_data = w[0];
        while (idx < 4 && budget < 200) begin
            acc = in_ready;
            @(posedge clk);
            #1 budget++;
            if (acc) begin
                idx++;
                if (idx < 4) in_data = w[idx];
                else         in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL b2b_accepts got %0d exp 4", idx);
        end
        while ((n_done - d0) < 4 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        checks++;
        if ((n_done - d0) != 4) begin
            errors++;
            $display("FAIL b2b_done_count got %0d exp 4", n_done - d0);
        end
        checks++;
        if ((n_tog - t0) != 4) begin
            errors++;
            $display("FAIL b2b_req_toggles got %0d exp 4", n_tog - t0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (recv.size() <= r0 + i) begin
                errors++;
                $display("FAIL b2b_word%0d got none exp %h", i, w[i]);
            end else if (recv[r0 + i] !== w[i]) begin
                errors++;
                $display("FAIL b2b_word%0d got %h exp %h", i, recv[r0 + i], w[i]);
            end
        end
        checks++;
        if ((n_unstable - u0) != 0) begin
            errors++;
            $display("FAIL b2b_data_stable got %0d changes exp 0", n_unstable - u0);
        end
        checks++;
        if (xfer_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final_req got %b exp 0", xfer_req);
        end
        ack_manual = 1'b0;
        echo_en = 1'b0;
    endtask

    task automatic test_timeout();
        logic exp_to;
        logic seen = 1'b0;
`ifdef CDC_BUS_TX_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        do_reset();
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = 32'h0BADF00D;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got %b exp 0", timeout_err);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== exp_to || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_at_limit got to=%b rdy=%b exp to=%b rdy=0", timeout_err, in_ready, exp_to);
        end
        ack_manual = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_late_ack got no done exp done");
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== exp_to || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got to=%b rdy=%b exp to=%b rdy=1", timeout_err, in_ready, exp_to);
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_idle_ack();
        test_reset_mid_wait();
        test_back_to_back();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cdc_bus_tx
`default_nettype wire

// File: doc/cdc_bus_tx.md
CDC_BUS_TX -- requirements
Module: cdc_bus_tx

Interface
REQ-001 SHALL have parameter Width, default 32: bit width of the transferred data word.
REQ-002 SHALL have parameter SyncDepth, default 2: number of flops in the ack synchronizer; legal values are 2 or greater.
REQ-003 SHALL have parameter TimeoutCycles, default 1024: number of WAIT_ACK cycles before a timeout is flagged; only used when the Configuration macro is defined.
REQ-004 SHALL have port clk, input, 1 bit: source-domain clock; this is the only clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, Width bits: word to send.
REQ-009 SHALL have port xfer_data, output, Width bits: registered word held stable for the destination domain.
REQ-010 SHALL have port xfer_req, output, 1 bit: registered request toggle.
REQ-011 SHALL have port xfer_ack, input, 1 bit: ack toggle from the destination domain; asynchronous to clk.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-013 SHALL have port timeout_err, output, 1 bit: sticky timeout flag.

Function
REQ-014 SHALL implement a two-phase toggle handshake; each transfer toggles xfer_req exactly once.
REQ-015 SHALL synchronize xfer_ack through SyncDepth flops to produce ack_s; no other logic SHALL use xfer_ack directly.
REQ-016 SHALL have two states, IDLE and WAIT_ACK; the reset state is IDLE.
REQ-017 SHALL drive in_ready = 1 in IDLE and 0 in WAIT_ACK; in_ready is combinational from state only and never depends on in_valid.
REQ-018 In IDLE with in_valid = 1, SHALL on that edge load xfer_data <= in_data, set xfer_req <= ~xfer_req, and go to WAIT_ACK.
REQ-019 SHALL change xfer_data only on an accept edge, so xfer_data is stable throughout WAIT_ACK.
REQ-020 In WAIT_ACK, when ack_s == xfer_req, SHALL return to IDLE and pulse done = 1 for one cycle on the same edge.
REQ-021 SHALL make in_ready high again on the cycle after done; back-to-back accepts are therefore possible.
REQ-022 Minimum accept-to-done latency SHALL be SyncDepth + 1 cycles after the xfer_ack toggle is visible at the synchronizer input.
REQ-023 In IDLE, SHALL ignore ack_s with no state change and no done pulse; a mismatch there is a destination protocol error and is outside this block's spec.
REQ-024 SHALL ignore in_valid and in_data while in WAIT_ACK.

Reset
REQ-025 On rst_n = 0, SHALL asynchronously clear: state = IDLE, xfer_req = 0, xfer_data = 0, done = 0, timeout_err = 0, synchronizer flops = 0, and the timeout counter = 0.
REQ-026 Reset during WAIT_ACK SHALL abandon the transfer without a done pulse; the destination end SHALL be reset in the same event.
REQ-027 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro CDC_BUS_TX_TIMEOUT_EN SHALL control the timeout feature.
REQ-029 When defined, SHALL count cycles spent in WAIT_ACK, clear the count on entry to WAIT_ACK, and set timeout_err to 1 when the count reaches TimeoutCycles.
REQ-030 When defined, timeout_err SHALL stay set until reset, and the FSM SHALL keep waiting.
REQ-031 When not defined, timeout_err SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-032 SHALL place the state encoding (IDLE = 0, WAIT_ACK = 1) in shared package cdc_pkg, together with the default SyncDepth constant.
REQ-033 SHALL synchronize the ack with one instance of the existing signal_sync sub-module, Width = 1, Depth = SyncDepth; no new sub-module is needed.

Verification
REQ-034 Reset then idle: in_ready = 1, xfer_req = 0, xfer_data = 0, done = 0.
REQ-035 Accept 0xDEADBEEF with in_valid for one cycle -> next cycle xfer_data = 0xDEADBEEF, xfer_req = 1, in_ready = 0; toggle xfer_ack to 1 -> done pulses exactly once 3 cycles later (SyncDepth = 2), and in_ready = 1 on the following cycle.
REQ-036 Hold in_valid high over 4 words driven by an echo-ack model -> xfer_req toggles 4 times, 4 done pulses, words received in order, xfer_data never changes in WAIT_ACK.
REQ-037 Assert rst_n = 0 mid-WAIT_ACK -> immediate IDLE, xfer_req = 0, no done pulse, in_ready = 1 after release.
REQ-038 Toggle xfer_ack while in IDLE -> no state change, no done pulse.
REQ-039 With CDC_BUS_TX_TIMEOUT_EN, TimeoutCycles = 8, and no ack -> timeout_err = 1 after 8 WAIT_ACK cycles and stays 1 after a late ack completes the transfer; without the macro -> timeout_err stays 0.
